// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
// word_packer: packs RATIO consecutive WIDTH-bit words into one wide beat,
// with flush support for emitting a zero-padded partial group.
// Revision: 1.0
// ============================================================================
module word_packer #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4,
  localparam int CW = $clog2(RATIO) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [CW-1:0]          out_count,
  input  logic                   out_ready
);

  localparam logic [CW-1:0] C_RATIO = CW'(RATIO);
  localparam logic [CW-1:0] C_LAST  = CW'(RATIO - 1);

  logic [RATIO-1:0][WIDTH-1:0] r_acc;
  logic [CW-1:0]               r_cnt;
  logic                        r_flush_pend;
  logic                        r_out_valid;
  logic [WIDTH*RATIO-1:0]      r_out_data;
  logic [CW-1:0]               r_out_count;

  logic                        w_slot_free;
  logic                        w_in_xfer;
  logic                        w_complete;
  logic                        w_emit_direct;
  logic                        w_emit_held;
  logic                        w_flush_req;
  logic [WIDTH*RATIO-1:0]      w_load_data;
  logic [CW-1:0]               w_load_count;

  assign w_slot_free   = !r_out_valid || out_ready;
  assign in_ready      = (r_cnt < C_RATIO) && !r_flush_pend;
  assign w_in_xfer     = in_valid && in_ready;
  assign w_complete    = w_in_xfer && (r_cnt == C_LAST);
  assign w_emit_direct = w_complete && w_slot_free;
  // A stalled full group and a pending flush both drain from the accumulator.
  assign w_emit_held   = ((r_cnt == C_RATIO) || r_flush_pend) && w_slot_free;
  // A full group waiting on the output already emits everything; a flush then adds nothing.
  assign w_flush_req   = flush && !r_flush_pend && (r_cnt != C_RATIO) && !w_complete &&
                         ((r_cnt != '0) || w_in_xfer);
  assign w_load_count  = w_emit_direct ? C_RATIO : r_cnt;

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    if (k == RATIO - 1) begin : g_last
      assign w_load_data[k*WIDTH +: WIDTH] = w_emit_direct ? in_data :
                                             ((CW'(k) < r_cnt) ? r_acc[k] : '0);
    end else begin : g_body
      assign w_load_data[k*WIDTH +: WIDTH] = (CW'(k) < r_cnt) ? r_acc[k] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_acc[r_cnt[CW-2:0]] <= in_data;
      end
      if (w_emit_direct || w_emit_held) begin
        r_cnt <= '0;
      end else if (w_in_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_emit_held) begin
        r_flush_pend <= 1'b0;
      end else if (w_flush_req) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (w_emit_direct || w_emit_held) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_count <= w_load_count;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_word_packer.sv
`default_nettype none
// ============================================================================
// tb_word_packer: directed self-checking bench for word_packer.
// Revision: 1.0
// ============================================================================
module tb_word_packer;

  localparam int WIDTH = 32;
  localparam int RATIO = 4;
  localparam int CW    = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic                   flush;
  logic                   out_valid;
  logic [WIDTH*RATIO-1:0] out_data;
  logic [CW-1:0]          out_count;
  logic                   out_ready;

  int total = 0;
  int bad   = 0;

  word_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] beat(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    tick();
    in_valid = 1'b1;
    in_data  = w;
  endtask

  task automatic idle();
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    int beats;
    int next;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // reset
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_count", out_count, 3'd0);
    chk("rst_out_data",  out_data,  128'd0);
    chk("rst_in_ready",  in_ready,  1'b1);

    // streaming: 48 words, no backpressure
    out_ready = 1'b1;
    beats = 0;
    next  = 1000;
    for (int c = 0; c < 56; c++) begin
      tick();
      if (out_valid) begin
        chk("stream_data", out_data, beat(next, next + 1, next + 2, next + 3));
        chk("stream_count", out_count, 3'd4);
        next += 4;
        beats++;
      end
      if (c < 48) begin
        chk("stream_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'(1000 + c);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream_beats", beats, 12);

    // backpressure: one beat held, second group parked in the accumulator
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'(1000 + i));
    idle();
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_data0", out_data, beat(1000, 1001, 1002, 1003));
    chk("bp_count0", out_count, 3'd4);
    chk("bp_in_ready", in_ready, 1'b0);
    idle();
    chk("bp_hold_data", out_data, beat(1000, 1001, 1002, 1003));
    chk("bp_hold_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    idle();
    chk("bp_valid1", out_valid, 1'b1);
    chk("bp_data1", out_data, beat(1004, 1005, 1006, 1007));
    chk("bp_count1", out_count, 3'd4);
    chk("bp_in_ready1", in_ready, 1'b1);
    idle();
    chk("bp_drained", out_valid, 1'b0);

    // flush of a 3-word partial group
    push(1000); push(1001); push(1002);
    tick(); in_valid = 1'b0; flush = 1'b1;
    idle();
    chk("fl3_in_ready", in_ready, 1'b0);
    chk("fl3_not_yet", out_valid, 1'b0);
    idle();
    chk("fl3_valid", out_valid, 1'b1);
    chk("fl3_count", out_count, 3'd3);
    chk("fl3_data", out_data, beat(1000, 1001, 1002, 0));
    chk("fl3_in_ready_after", in_ready, 1'b1);
    idle();
    chk("fl3_drained", out_valid, 1'b0);

    // flush with nothing held is a no-op
    tick(); flush = 1'b1;
    idle();
    chk("fl0_valid_a", out_valid, 1'b0);
    chk("fl0_in_ready", in_ready, 1'b1);
    idle();
    chk("fl0_valid_b", out_valid, 1'b0);

    // flush together with the completing word
    push(1000); push(1001); push(1002); push(1003);
    flush = 1'b1;
    idle();
    chk("fl4_valid", out_valid, 1'b1);
    chk("fl4_count", out_count, 3'd4);
    chk("fl4_data", out_data, beat(1000, 1001, 1002, 1003));
    idle();
    chk("fl4_no_extra_a", out_valid, 1'b0);
    chk("fl4_in_ready", in_ready, 1'b1);
    idle();
    chk("fl4_no_extra_b", out_valid, 1'b0);

    // flush together with the 2nd word
    push(1000); push(1001);
    flush = 1'b1;
    idle();
    chk("fl2_in_ready", in_ready, 1'b0);
    chk("fl2_not_yet", out_valid, 1'b0);
    idle();
    chk("fl2_valid", out_valid, 1'b1);
    chk("fl2_count", out_count, 3'd2);
    chk("fl2_data", out_data, beat(1000, 1001, 0, 0));
    idle();

    // asynchronous reset with a stalled beat and a partial group held
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'(2000 + i));
    idle();
    chk("ar_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_count", out_count, 3'd0);
    chk("ar_data", out_data, 128'd0);
    chk("ar_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(1000); push(1001); push(1002); push(1003);
    idle();
    chk("ar_beat_valid", out_valid, 1'b1);
    chk("ar_beat_data", out_data, beat(1000, 1001, 1002, 1003));
    chk("ar_beat_count", out_count, 3'd4);
    idle();
    chk("ar_single_beat", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
